// File: rtl/vx_elastic_pipe.sv
// ----------------------------------------------------------------------------
// vx_elastic_pipe
//   Valid/ready elastic pipeline of DEPTH register stages with bubble
//   collapsing. An empty stage always takes data from the stage before it, so
//   entries pack toward the output while the output is stalled. ready_in drops
//   only when every stage holds data and the output is not draining.
//   Also provides a synchronous flush and a registered occupancy counter.
//   DEPTH = 0 makes the block a combinational passthrough.
//
// Ports
//   clk        in   1      clock
//   reset      in   1      synchronous, active-high reset
//   flush      in   1      discard all in-flight entries (next cycle)
//   valid_in   in   1      upstream valid
//   data_in    in   DATAW  upstream payload
//   ready_in   out  1      pipe accepts this cycle (never depends on valid_in)
//   valid_out  out  1      last stage holds data
//   data_out   out  DATAW  last stage payload
//   ready_out  in   1      downstream ready
//   count      out  CNTW   number of valid stages
// ----------------------------------------------------------------------------

// Simulation-time properties of the pipe: counter consistency and output hold.
module vx_elastic_pipe_checker #(
   parameter int DEPTH = 2,
   parameter int DATAW = 1,
   parameter int CNTW  = 2
) (
   input logic             clk,
   input logic             reset,
   input logic [DEPTH-1:0] v,
   input logic [CNTW-1:0]  count,
   input logic             valid_out,
   input logic             ready_out,
   input logic [DATAW-1:0] data_out
);

   // The occupancy counter must always match the number of valid stages.
   a_count_matches_valid: assert property (
      @(posedge clk) disable iff (reset) (32'(count) == $countones(v)))
      else $error("occupancy count %0d differs from valid stage population", count);

   // A presented but not accepted output must stay unchanged.
   a_output_held: assert property (
      @(posedge clk) (valid_out && !ready_out && !reset) |=> $stable(data_out))
      else $error("data_out changed while stalled");

endmodule

module vx_elastic_pipe #(
   parameter int DATAW  = 1,
   parameter int DEPTH  = 2,
   parameter int RESETW = 0,
   parameter logic [((RESETW > 0) ? RESETW : 1)-1:0] INIT_VALUE = '0,
   parameter int CNTW   = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [DATAW-1:0] data_in,
   output logic             ready_in,
   output logic             valid_out,
   output logic [DATAW-1:0] data_out,
   input  logic             ready_out,
   output logic [CNTW-1:0]  count
);

   // Mask selecting the payload bits that take INIT_VALUE on reset.
   function automatic logic [DATAW-1:0] reset_mask();
      logic [DATAW-1:0] m;
      m = {DATAW{1'b0}};
      for (int b = 0; b < DATAW; b++) begin
         m[b] = (b < RESETW);
      end
      return m;
   endfunction

   if (DEPTH == 0) begin : g_pass

      // clk/reset/flush have no function without storage.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, reset, flush};

      assign valid_out = valid_in;
      assign data_out  = data_in;
      assign ready_in  = ready_out;
      assign count     = {CNTW{1'b0}};

   end else begin : g_pipe

      localparam logic [DATAW-1:0] RST_MASK  = reset_mask();
      localparam logic [DATAW-1:0] INIT_FILL = DATAW'(INIT_VALUE) & RST_MASK;

      logic [DEPTH-1:0] v_r;
      logic [DATAW-1:0] data_r [DEPTH];
      logic [DEPTH-1:0] en_s;
      logic [DEPTH-1:0] up_v_s;
      logic [DATAW-1:0] up_d_s [DEPTH];
      logic [CNTW-1:0]  count_r;
      logic             fire_in_s;
      logic             fire_out_s;

      // Stage enables. en[i] = !v[i] || en[i+1] unrolls to: stage i may
      // advance unless every stage from i to the output is full and the output
      // is stalled. Written flat so the chain has no self-referencing vector.
      always_comb begin
         logic full;
         full = 1'b0;
         en_s = {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            full = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
               full = full & v_r[j];
            end
            en_s[i] = ready_out | ~full;
         end
      end

      // Upstream source of each stage: data_in for stage 0, previous stage after.
      for (genvar i = 0; i < DEPTH; i++) begin : g_up
         if (i == 0) begin : g_first
            assign up_v_s[i] = valid_in;
            assign up_d_s[i] = data_in;
         end else begin : g_next
            assign up_v_s[i] = v_r[i-1];
            assign up_d_s[i] = data_r[i-1];
         end
      end

      assign fire_in_s  = valid_in & en_s[0];
      assign fire_out_s = v_r[DEPTH-1] & ready_out;

      // Stage valid bits and payloads. Reset only rewrites the low RESETW
      // payload bits; flush clears valid bits but leaves payloads alone.
      always_ff @(posedge clk) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
               v_r[i]    <= 1'b0;
               data_r[i] <= (data_r[i] & ~RST_MASK) | INIT_FILL;
            end else begin
               if (flush) begin
                  v_r[i] <= 1'b0;
               end else if (en_s[i]) begin
                  v_r[i] <= up_v_s[i];
               end else begin
                  v_r[i] <= v_r[i];
               end
               if (en_s[i] && up_v_s[i]) begin
                  data_r[i] <= up_d_s[i];
               end else begin
                  data_r[i] <= data_r[i];
               end
            end
         end
      end

      // Occupancy counter: an input accepted during flush is discarded, so the
      // counter simply returns to zero.
      always_ff @(posedge clk) begin
         if (reset || flush) begin
            count_r <= {CNTW{1'b0}};
         end else if (fire_in_s && !fire_out_s) begin
            count_r <= count_r + CNTW'(1);
         end else if (!fire_in_s && fire_out_s) begin
            count_r <= count_r - CNTW'(1);
         end else begin
            count_r <= count_r;
         end
      end

      assign ready_in  = en_s[0];
      assign valid_out = v_r[DEPTH-1];
      assign data_out  = data_r[DEPTH-1];
      assign count     = count_r;

      vx_elastic_pipe_checker #(
         .DEPTH (DEPTH),
         .DATAW (DATAW),
         .CNTW  (CNTW)
      ) u_checker (
         .clk       (clk),
         .reset     (reset),
         .v         (v_r),
         .count     (count_r),
         .valid_out (valid_out),
         .ready_out (ready_out),
         .data_out  (data_out)
      );

   end

endmodule
